baud_gen: RTL and testbench

Parametrised baud-rate generator and successor to the fixed even-ratio `divide` block. It produces a fractional-rate oversample tick, bit-rate and mid-bit strobes, and a square bit clock from `clk_in`. The divisor can be updated glitch-free at run time, and the bit phase can be realigned on demand. The block feeds the UART transmitter (`tick_bit`) and receiver (`tick_os`, `tick_mid`, `restart`).

---
 rtl/serial_pkg.sv | 15 +
 rtl/baud_gen_if.sv | 32 +++
 rtl/baud_prescaler.sv | 90 +++++++++
 rtl/baud_gen.sv | 70 +++++++
 tb/tb_baud_gen.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// Shared serial-block definitions: default baud generator sizing and the
// divisor record used by the UART register block.
package serial_pkg;

    localparam int DEF_WIDTH      = 14;
    localparam int DEF_FRAC_BITS  = 4;
    localparam int DEF_OVERSAMPLE = 16;

    // Integer and fractional parts of clk_in cycles per oversample tick.
    typedef struct packed {
        logic [DEF_WIDTH-1:0]     div_int;
        logic [DEF_FRAC_BITS-1:0] div_frac;
    } baud_div_t;

endpackage

// File: rtl/baud_gen_if.sv
// Control and strobe bundle between a baud generator and its user.
interface baud_gen_if
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) ();

    logic                 en;
    logic [WIDTH-1:0]     divisor;
    logic [FRAC_BITS-1:0] frac;
    logic                 load;
    logic                 restart;
    logic                 tick_os;
    logic                 tick_mid;
    logic                 tick_bit;
    logic                 clk_out;
    logic                 pending;

    // Controller side: drives rate and phase controls, receives strobes.
    modport master (
        output en, divisor, frac, load, restart,
        input  tick_os, tick_mid, tick_bit, clk_out, pending
    );

    // Generator side.
    modport slave (
        input  en, divisor, frac, load, restart,
        output tick_os, tick_mid, tick_bit, clk_out, pending
    );

endinterface

// File: rtl/baud_prescaler.sv
// Fractional prescaler: counts clk_in cycles down to each oversample tick,
// dithering the period between N and N+1 with a fractional accumulator.
// Holds the active and pending divisor pairs.
module baud_prescaler
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 en,
    input  logic [WIDTH-1:0]     divisor,
    input  logic [FRAC_BITS-1:0] frac,
    input  logic                 load,
    input  logic                 restart,
    output logic                 tick_os,
    output logic                 pending
);

    localparam logic [WIDTH:0]   CNT_ONE = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] N_ONE   = WIDTH'(1);

    logic [WIDTH-1:0]     n_a_reg, n_p_reg;
    logic [FRAC_BITS-1:0] f_a_reg, f_p_reg;
    logic [FRAC_BITS-1:0] acc_reg;
    logic [WIDTH:0]       cnt_reg;
    logic                 pending_reg;

    logic                 run_zero;
    logic                 apply;
    logic [WIDTH-1:0]     n_next;
    logic [FRAC_BITS-1:0] f_next;
    logic [WIDTH-1:0]     n_eff;
    logic [FRAC_BITS:0]   sum;
    logic [WIDTH:0]       reload;

    // A reload boundary is either a natural terminal count or a restart; both
    // promote the pending divisor, and the new values govern the next period.
    // The accumulator carry only matters in the reload cycle, so it is used
    // directly from the sum rather than stored.
    assign run_zero = en && (cnt_reg == '0);
    assign apply    = restart || run_zero;
    assign n_next   = pending_reg ? n_p_reg : n_a_reg;
    assign f_next   = pending_reg ? f_p_reg : f_a_reg;
    assign n_eff    = (n_next == '0) ? N_ONE : n_next;
    assign sum      = {1'b0, acc_reg} + {1'b0, f_next};
    assign reload   = ({1'b0, n_eff} - CNT_ONE) + {{WIDTH{1'b0}}, sum[FRAC_BITS]};

    // Restart swallows the strobe; reset gating keeps outputs low while held.
    assign tick_os = reset && run_zero && !restart;
    assign pending = pending_reg;

    // Divisor capture/promotion and the period counter with its accumulator.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            n_a_reg     <= '0;
            n_p_reg     <= '0;
            f_a_reg     <= '0;
            f_p_reg     <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            pending_reg <= 1'b0;
        end else begin
            if (load) begin
                n_p_reg <= divisor;
                f_p_reg <= frac;
            end
            if (load) begin
                pending_reg <= 1'b1;
            end else if (apply) begin
                pending_reg <= 1'b0;
            end
            if (apply) begin
                n_a_reg <= n_next;
                f_a_reg <= f_next;
            end
            if (restart) begin
                cnt_reg <= {1'b0, n_eff} - CNT_ONE;
                acc_reg <= '0;
            end else if (run_zero) begin
                cnt_reg <= reload;
                acc_reg <= sum[FRAC_BITS-1:0];
            end else if (en) begin
                cnt_reg <= cnt_reg - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/baud_gen.sv
// Baud-rate generator: oversample tick from the prescaler, mid-bit and
// end-of-bit strobes from the oversample phase, and a square bit clock.
module baud_gen
    import serial_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic     clk_in,
    input  logic     reset,
    baud_gen_if.slave bus
);

    localparam int              OS_W    = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_ONE  = OS_W'(1);

    logic            tick_os;
    logic            tick_mid;
    logic            tick_bit;
    logic            pending;
    logic [OS_W-1:0] os_cnt_reg;
    logic            clk_out_reg;

    baud_prescaler #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_prescaler (
        .clk_in  (clk_in),
        .reset   (reset),
        .en      (bus.en),
        .divisor (bus.divisor),
        .frac    (bus.frac),
        .load    (bus.load),
        .restart (bus.restart),
        .tick_os (tick_os),
        .pending (pending)
    );

    assign tick_mid = tick_os && (os_cnt_reg == OS_MID);
    assign tick_bit = tick_os && (os_cnt_reg == OS_LAST);

    // Oversample phase counter and bit clock; restart realigns both to the
    // start of a bit with the bit clock low.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            os_cnt_reg  <= '0;
            clk_out_reg <= 1'b0;
        end else if (bus.restart) begin
            os_cnt_reg  <= '0;
            clk_out_reg <= 1'b0;
        end else begin
            if (tick_os) begin
                os_cnt_reg <= (os_cnt_reg == OS_LAST) ? '0 : os_cnt_reg + OS_ONE;
            end
            if (tick_mid || tick_bit) begin
                clk_out_reg <= ~clk_out_reg;
            end
        end
    end

    assign bus.tick_os  = tick_os;
    assign bus.tick_mid = tick_mid;
    assign bus.tick_bit = tick_bit;
    assign bus.clk_out  = clk_out_reg;
    assign bus.pending  = pending;

endmodule

// File: tb/tb_baud_gen.sv
// Directed bench for baud_gen with N/F/OVERSAMPLE = default 14/4/16 sizing.
module tb_baud_gen;

    logic clk_in;
    logic reset;
    int   total;
    int   bad;
    int   gap;
    int   sum;

    baud_gen_if #(.WIDTH(14), .FRAC_BITS(4)) bus ();

    baud_gen #(.WIDTH(14), .FRAC_BITS(4), .OVERSAMPLE(16)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; inputs may be changed right after this.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Count cycles until the selected strobe (0 os, 1 mid, 2 bit) is seen,
    // dropping load/restart pulses on the first step. Bounded by max_cyc.
    task automatic wait_sig(input int sel, input int max_cyc, output int cycles);
        logic hit;
        cycles = 0;
        hit = 1'b0;
        while (!hit && cycles < max_cyc) begin
            step();
            bus.load    = 1'b0;
            bus.restart = 1'b0;
            cycles++;
            @(negedge clk_in);
            case (sel)
                0:       hit = bus.tick_os;
                1:       hit = bus.tick_mid;
                default: hit = bus.tick_bit;
            endcase
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset       = 1'b0;
        bus.en      = 1'b0;
        bus.divisor = '0;
        bus.frac    = '0;
        bus.load    = 1'b0;
        bus.restart = 1'b0;

        // Reset state
        repeat (3) step();
        @(negedge clk_in);
        check("rst_tick_os", bus.tick_os, 0);
        check("rst_tick_mid", bus.tick_mid, 0);
        check("rst_tick_bit", bus.tick_bit, 0);
        check("rst_clk_out", bus.clk_out, 0);
        check("rst_pending", bus.pending, 0);
        step();
        bus.en = 1'b1;
        @(negedge clk_in);
        check("rst_en_no_tick", bus.tick_os, 0);

        // Release: N=0 clamps to 1, so a tick every cycle from the first one
        @(posedge clk_in);
        #1 reset = 1'b1;
        @(negedge clk_in);
        check("first_tick", bus.tick_os, 1);
        for (int i = 2; i <= 11; i++) begin
            step();
            @(negedge clk_in);
            check("n0_tick", bus.tick_os, 1);
            check("n0_mid", bus.tick_mid, (i == 8) ? 1 : 0);
        end
        check("n0_clk_out_high", bus.clk_out, 1);

        // Load N=4, then restart coinciding with cnt==0
        step();
        bus.load = 1'b1;
        bus.divisor = 14'd4;
        bus.frac = 4'd0;
        @(negedge clk_in);
        check("load_pending_lag", bus.pending, 0);
        step();
        bus.load = 1'b0;
        bus.restart = 1'b1;
        @(negedge clk_in);
        check("restart_pending_before", bus.pending, 1);
        check("restart_no_tick", bus.tick_os, 0);
        step();
        bus.restart = 1'b0;
        @(negedge clk_in);
        check("restart_clk_low", bus.clk_out, 0);
        check("restart_applied", bus.pending, 0);
        wait_sig(0, 50, gap);
        check("restart_to_tick", gap + 1, 4);
        check("restart_os0_no_mid", bus.tick_mid, 0);

        // N=4: mid 28 after first tick, then bit/mid every 32, clk_out 32/32
        wait_sig(1, 200, gap);
        check("n4_mid_gap0", gap, 28);
        wait_sig(2, 200, gap);
        check("n4_mid_to_bit", gap, 32);
        check("n4_clk_high", bus.clk_out, 1);
        wait_sig(1, 200, gap);
        check("n4_bit_to_mid", gap, 32);
        check("n4_clk_low", bus.clk_out, 0);
        wait_sig(2, 200, gap);
        check("n4_mid_to_bit2", gap, 32);

        // N=4 F=0.5 after restart: spacing 4,5,4,5..., 16 ticks in 72 cycles
        step();
        bus.load = 1'b1;
        bus.divisor = 14'd4;
        bus.frac = 4'd8;
        step();
        bus.load = 1'b0;
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        @(negedge clk_in);
        wait_sig(0, 50, gap);
        check("frac_first", gap + 1, 4);
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            wait_sig(0, 50, gap);
            check("frac_gap", gap, (i % 2 == 0) ? 4 : 5);
            sum += gap;
        end
        check("frac_sum16", sum, 72);

        // Load N=10 two cycles into a 4-cycle period
        step();
        step();
        bus.load = 1'b1;
        bus.divisor = 14'd10;
        bus.frac = 4'd0;
        @(negedge clk_in);
        check("midload_pending_lag", bus.pending, 0);
        step();
        bus.load = 1'b0;
        @(negedge clk_in);
        check("midload_pending", bus.pending, 1);
        wait_sig(0, 50, gap);
        check("midload_period_kept", gap + 3, 4);
        check("midload_pending_at_edge", bus.pending, 1);
        wait_sig(0, 50, gap);
        check("midload_new_spacing", gap, 10);
        check("midload_pending_clear", bus.pending, 0);

        // en low for 7 cycles mid-period delays the strobe by 7
        repeat (3) step();
        bus.en = 1'b0;
        repeat (7) begin
            step();
            @(negedge clk_in);
            check("freeze_no_tick", bus.tick_os, 0);
        end
        check("freeze_clk_hold", bus.clk_out, 0);
        bus.en = 1'b1;
        wait_sig(0, 50, gap);
        check("freeze_delay", gap + 10, 17);

        // Reset mid-bit with clk_out high and a divisor pending
        wait_sig(1, 200, gap);
        check("n10_to_mid", gap, 40);
        step();
        bus.load = 1'b1;
        bus.divisor = 14'd4;
        @(negedge clk_in);
        check("pre_reset_clk_high", bus.clk_out, 1);
        step();
        bus.load = 1'b0;
        @(negedge clk_in);
        check("pre_reset_pending", bus.pending, 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_clk_out", bus.clk_out, 0);
        check("async_rst_pending", bus.pending, 0);
        check("async_rst_tick_os", bus.tick_os, 0);
        check("async_rst_tick_mid", bus.tick_mid, 0);
        check("async_rst_tick_bit", bus.tick_bit, 0);
        step();
        step();
        @(negedge clk_in);
        check("held_rst_no_tick", bus.tick_os, 0);
        @(posedge clk_in);
        #1 reset = 1'b1;
        @(negedge clk_in);
        check("post_rst_first_tick", bus.tick_os, 1);
        check("post_rst_pending", bus.pending, 0);
        step();
        @(negedge clk_in);
        check("post_rst_n0_tick", bus.tick_os, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
